// File: rtl/divider_seq_if.sv
// Start/done handshake and operand/result bus for the sequential divider.
// Vectors use big-endian bit numbering: bit 0 is the MSB.
interface divider_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic               sgn;
    logic [0:WIDTH-1]   a;
    logic [0:WIDTH-1]   b;
    logic [0:WIDTH-1]   q;
    logic [0:WIDTH-1]   r;
    logic               busy;
    logic               done;
    logic               divZero;

    modport master (
        output start, sgn, a, b,
        input  q, r, busy, done, divZero
    );

    modport slave (
        input  start, sgn, a, b,
        output q, r, busy, done, divZero
    );
endinterface

// File: rtl/divider_seq.sv
// Radix-2 restoring divider, one quotient bit per clock, signed/unsigned.
// Sign handling is done on magnitudes up front and fixed up in a single FIX cycle.
module divider_seq #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    divider_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    localparam int CNT_W = $clog2(WIDTH);

    state_t             r_state;
    state_t             w_next;

    logic               r_neg_q;
    logic               r_neg_a;
    logic               r_b_zero;
    logic [0:WIDTH-1]   r_rem;
    logic [0:WIDTH-1]   r_dvd;
    logic [0:WIDTH-1]   r_div;
    logic [0:WIDTH-1]   r_q;
    logic [0:WIDTH-1]   r_r;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_div_zero;

    logic               w_accept;
    logic               w_last;
    logic               w_b_is_zero;
    logic [0:WIDTH-1]   w_a_abs;
    logic [0:WIDTH-1]   w_b_abs;
    logic [0:WIDTH]     w_shift;
    logic [0:WIDTH]     w_trial;

    assign w_accept    = (r_state == S_IDLE) && bus.start;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_b_is_zero = (bus.b == '0);
    assign w_a_abs     = (bus.sgn && bus.a[0]) ? -bus.a : bus.a;
    assign w_b_abs     = (bus.sgn && bus.b[0]) ? -bus.b : bus.b;

    // Shift the next dividend bit into the partial remainder; trial bit 0 is the borrow/sign.
    assign w_shift = {r_rem, r_dvd[0]};
    assign w_trial = w_shift - {1'b0, r_div};

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: assign the default first so no path through the case leaves w_next unassigned (latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (bus.start) w_next = w_b_is_zero ? S_FIX : S_RUN;
            S_RUN:  if (w_last)    w_next = S_FIX;
            S_FIX:                 w_next = S_DONE;
            S_DONE:                w_next = S_IDLE;
            default:               w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neg_q    <= 1'b0;
            r_neg_a    <= 1'b0;
            r_b_zero   <= 1'b0;
            r_rem      <= '0;
            r_dvd      <= '0;
            r_div      <= '0;
            r_q        <= '0;
            r_r        <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_neg_q    <= bus.sgn && (bus.a[0] ^ bus.b[0]);
                r_neg_a    <= bus.sgn && bus.a[0];
                r_b_zero   <= w_b_is_zero;
                // A zero divisor skips the iterations and reports the raw dividend as remainder.
                r_dvd      <= w_b_is_zero ? bus.a : w_a_abs;
                r_div      <= w_b_abs;
                r_rem      <= '0;
                r_cnt      <= '0;
                r_busy     <= 1'b1;
                r_div_zero <= 1'b0;
            end
            case (r_state)
                S_RUN: begin
                    r_rem <= w_trial[0] ? w_shift[1:WIDTH] : w_trial[1:WIDTH];
                    r_dvd <= {r_dvd[1:WIDTH-1], ~w_trial[0]};
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: begin
                    if (r_b_zero) begin
                        r_q        <= '1;
                        r_r        <= r_dvd;
                        r_div_zero <= 1'b1;
                    end else begin
                        r_q <= r_neg_q ? -r_dvd : r_dvd;
                        r_r <= r_neg_a ? -r_rem : r_rem;
                    end
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.q       = r_q;
    assign bus.r       = r_r;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.divZero = r_div_zero;
endmodule
